// File: rtl/width_conv_pkg.sv
// Shared helpers for the width converters: counter sizing and beat-to-lane mapping.
package width_conv_pkg;

   function automatic int unsigned cnt_w(input int unsigned ratio);
      return (ratio < 2) ? 1 : $clog2(ratio);
   endfunction

   // Lane that beat k of a word occupies.
   function automatic int unsigned lane_of(input int unsigned k, input int unsigned ratio,
                                           input bit msb_first);
      return msb_first ? (ratio - 1 - k) : k;
   endfunction

endpackage

// File: rtl/width_conv_oreg.sv
// Output word register with valid/ready hold; a new word may replace one that drains this cycle.
module width_conv_oreg #(
   parameter int unsigned DW = 16,
   parameter int unsigned KW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] data,
   input  logic [KW-1:0] keep,
   input  logic          last,
   output logic          can_load,
   output logic          valid_out,
   input  logic          ready_out,
   output logic [DW-1:0] data_out,
   output logic [KW-1:0] keep_out,
   output logic          last_out
);

   assign can_load = !valid_out || ready_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         keep_out  <= '0;
         last_out  <= 1'b0;
      end else if (load) begin
         valid_out <= 1'b1;
         data_out  <= data;
         keep_out  <= keep;
         last_out  <= last;
      end else if (ready_out) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: rtl/width_up_pack.sv
// Narrow-to-wide packer: collects RATIO beats (or fewer, closed by last_in) into one word.
module width_up_pack
   import width_conv_pkg::*;
#(
   parameter int unsigned IN_W      = 8,
   parameter int unsigned RATIO     = 2,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   output logic                  ready_in,
   input  logic [IN_W-1:0]       data_in,
   input  logic                  last_in,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic [IN_W*RATIO-1:0] data_out,
   output logic [RATIO-1:0]      keep_out,
   output logic                  last_out
);

   localparam int unsigned OUT_W = IN_W * RATIO;
   localparam int unsigned CW    = cnt_w(RATIO);

   generate
      if (RATIO < 2 || IN_W < 1) begin : g_bad_params
         $error("width_up_pack: RATIO must be >= 2 and IN_W >= 1");
      end
   endgenerate

   logic [CW-1:0]    cnt;
   logic [OUT_W-1:0] acc;
   logic [RATIO-1:0] kacc;
   logic [OUT_W-1:0] acc_next;
   logic [RATIO-1:0] keep_next;
   logic [OUT_W-1:0] word;
   logic             accept;
   logic             full;
   logic             close;
   int unsigned      lane;

   assign accept = valid_in && ready_in;
   assign full   = (cnt == CW'(RATIO - 1));
   assign close  = accept && (full || last_in);

   always_comb begin
      acc_next  = acc;
      keep_next = kacc;
      word      = '0;
      lane      = lane_of({{(32-CW){1'b0}}, cnt}, RATIO, MSB_FIRST);
      for (int unsigned j = 0; j < RATIO; j++) begin
         if (j == lane) begin
            acc_next[j*IN_W +: IN_W] = data_in;
            keep_next[j]             = 1'b1;
         end
         // Unfilled lanes are masked so an early flush never exposes stale bits.
         if (keep_next[j]) word[j*IN_W +: IN_W] = acc_next[j*IN_W +: IN_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         acc  <= '0;
         kacc <= '0;
      end else if (accept) begin
         if (close) begin
            cnt  <= '0;
            acc  <= '0;
            kacc <= '0;
         end else begin
            cnt  <= cnt + CW'(1);
            acc  <= acc_next;
            kacc <= keep_next;
         end
      end
   end

   width_conv_oreg #(
      .DW (OUT_W),
      .KW (RATIO)
   ) u_oreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (close),
      .data      (word),
      .keep      (keep_next),
      .last      (last_in && !full),
      .can_load  (ready_in),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .data_out  (data_out),
      .keep_out  (keep_out),
      .last_out  (last_out)
   );

endmodule

// File: doc/width_up_pack.md
Name: width_up_pack

Overview:
- Parametrised narrow-to-wide packer; generalises the fixed 8-to-16 converter to any input width and any pack ratio.
- Adds valid/ready backpressure on both sides, selectable lane order, and early flush of a partial word via last_in with per-lane keep.
- Sits between a narrow byte/word source and a wide datapath consumer.

Parameters:
IN_W, 8, input beat width in bits (>=1)
RATIO, 2, input beats per output word (>=2); OUT_W = IN_W*RATIO
MSB_FIRST, 1, 1: first beat lands in the most-significant lane; 0: first beat lands in the least-significant lane

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  input beat valid
ready_in  output  1  packer can accept a beat
data_in  input  IN_W  input beat
last_in  input  1  beat is the final one of a word; flush early
valid_out  output  1  output word valid
ready_out  input  1  consumer accepts the word
data_out  output  OUT_W  packed word
keep_out  output  RATIO  keep_out[j]=1 means data_out[j*IN_W +: IN_W] holds real data
last_out  output  1  word was closed by last_in, not by filling

Behaviour:
- Reset (async assert, sync release): valid_out=0, data_out=0, keep_out=0, last_out=0, beat counter=0, accumulator=0. A partially filled word is discarded.
- A beat is accepted when valid_in && ready_in. A beat with valid_in high and ready_in low is ignored, and the source holds it.
- ready_in = !valid_out || ready_out. Combinational from ready_out and the registered valid_out, so full throughput is possible.
- Lane for beat index k (0..RATIO-1):
  - MSB_FIRST=1: lane RATIO-1-k.
  - MSB_FIRST=0: lane k.
  - Beat written to accumulator bits [lane*IN_W +: IN_W] and its keep bit set.
- Counter width is $clog2(RATIO). It advances on each accepted beat and returns to 0 when a word closes. It wraps cleanly for non-power-of-2 RATIO.
- Word closes on the accepted beat with k==RATIO-1 or last_in=1. On the next clk edge:
  - data_out = accumulator including this beat, with unfilled lanes forced to 0.
  - keep_out = filled lanes.
  - last_out = last_in && (k != RATIO-1). last_in on a naturally full beat gives last_out=0.
  - valid_out=1.
  - Accumulator and keep are cleared.
- Latency: valid_out rises the cycle after the closing beat is accepted. With ready_out tied 1, valid_out is a one-cycle pulse per word.
- Output hold: while valid_out && !ready_out, data_out, keep_out and last_out stay stable and ready_in=0.
- Simultaneous drain and close: if valid_out && ready_out and a closing beat is accepted in the same cycle, the new word replaces the old one and valid_out stays 1.
- After a handshake with no new word, valid_out goes to 0. data_out and keep_out keep their last values.
- Beats of the next word may be accepted while an older word is waiting, but only when ready_in=1 (i.e. never while output is stalled).
- Elaboration error if RATIO<2 or IN_W<1.

Decomposition:
- Package width_conv_pkg: lane-offset function lane_of(k, RATIO, MSB_FIRST) and counter-width helper; shared with a future down-converter.
- One sub-module, width_conv_oreg: output register plus valid/ready hold logic (data, keep, last), reusable by the down-converter.
- Top holds the counter, accumulator and close detect.

Test Plan:
1. Defaults, ready_out=1, feed 2D then 61 on consecutive accepted beats -> the next cycle has valid_out=1 for one cycle, data_out=16'h2D61, keep_out=2'b11, last_out=0.
2. Backpressure:
   - Stimulus: ready_out=0, then send DA,16,5A.
   - After DA16 forms: ready_in=0 and 5A is not accepted; data_out stays 16'hDA16 for 10 cycles.
   - Raise ready_out: DA16 handshakes; then 5A,DB accepted -> 16'h5ADB.
3. Partial flush: single beat F7 with last_in=1 -> data_out=16'hF700, keep_out=2'b10, last_out=1. The next pair 68,77 -> 16'h6877, keep 2'b11, last_out=0.
4. RATIO=4, MSB_FIRST=0: beats 11,22,33,44 -> data_out=32'h44332211, keep_out=4'hF. Beats A0,4C with last_in on 4C -> 32'h00004CA0, keep_out=4'h3, last_out=1.
5. Reset mid-word: accept 68, pulse rst_n low for 3 ns between edges -> outputs immediately 0. Then C1,F5 -> 16'hC1F5; 68 never appears.
6. Throughput: 40 back-to-back pairs with valid_in held high and ready_out=1 -> 40 words in 81 cycles, each matching {a,b}, and ready_in never drops.
